// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: Tuse/Tnew stall/flush scheduler plus mult/div busy sequencer.
// Optional macro STALL_PERF_CNT_EN adds the stall_cnt performance counter.
module hazard_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic [1:0] tuse_rs_D,
  input  logic [1:0] tuse_rt_D,
  input  logic [4:0] wreg_E,
  input  logic [1:0] tnew_E,
  input  logic [4:0] wreg_M,
  input  logic [1:0] tnew_M,
  input  logic       md_start_E,
  input  logic       md_is_div_E,
  input  logic       md_use_D,
  output logic       stall_PC,
  output logic       stall_FtoD,
  output logic       flush_DtoE,
  output logic       md_busy,
  output logic       md_done
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic r_done, w_done_nxt;
  logic w_stall_rs, w_stall_rt, w_stall_md, w_stall;
  // A reader stalls only if it needs the value strictly before the producer has it
  assign w_stall_rs = (rs_D != 5'd0) && (tuse_rs_D != 2'd3) &&
                      ((rs_D == wreg_E && tuse_rs_D < tnew_E) || (rs_D == wreg_M && tuse_rs_D < tnew_M));
  assign w_stall_rt = (rt_D != 5'd0) && (tuse_rt_D != 2'd3) &&
                      ((rt_D == wreg_E && tuse_rt_D < tnew_E) || (rt_D == wreg_M && tuse_rt_D < tnew_M));
  assign w_stall_md = md_use_D && (md_busy || md_start_E);
  assign w_stall    = w_stall_rs || w_stall_rt || w_stall_md;
  assign stall_PC   = w_stall && !RESET;
  assign stall_FtoD = w_stall && !RESET;
  assign flush_DtoE = w_stall && !RESET;
  assign md_busy    = (r_state == BUSY);
  assign md_done    = r_done;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
    end
  end
  // A new start always reloads, so an overlapping op silently replaces the old one
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    if (md_start_E) begin
      w_state_nxt = BUSY;
      w_cnt_nxt   = md_is_div_E ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
    end else if (r_state == BUSY) begin
      w_state_nxt = (r_cnt == 4'd1) ? IDLE : BUSY;
      w_cnt_nxt   = r_cnt - 4'd1;
      w_done_nxt  = (r_cnt == 4'd1);
    end
  end
`ifdef STALL_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  always_ff @(posedge CLK) r_stall_cnt <= RESET ? 32'd0 : r_stall_cnt + {31'd0, w_stall};
  assign stall_cnt = r_stall_cnt;
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: table vectors, hand sequences and randomized run against a cycle-time model.
module tb_hazard_stall_ctrl;
  logic CLK = 1'b0;
  logic RESET;
  logic [4:0] rs_D, rt_D, wreg_E, wreg_M;
  logic [1:0] tuse_rs_D, tuse_rt_D, tnew_E, tnew_M;
  logic md_start_E, md_is_div_E, md_use_D;
  logic stall_PC, stall_FtoD, flush_DtoE, md_busy, md_done;
`ifdef STALL_PERF_CNT_EN
  logic [31:0] stall_cnt;
`endif
  hazard_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .CLK(CLK), .RESET(RESET),
    .rs_D(rs_D), .rt_D(rt_D), .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D),
    .wreg_E(wreg_E), .tnew_E(tnew_E), .wreg_M(wreg_M), .tnew_M(tnew_M),
    .md_start_E(md_start_E), .md_is_div_E(md_is_div_E), .md_use_D(md_use_D),
    .stall_PC(stall_PC), .stall_FtoD(stall_FtoD), .flush_DtoE(flush_DtoE),
    .md_busy(md_busy), .md_done(md_done)
`ifdef STALL_PERF_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  // model: cycle number, time and length of the latest accepted md op, stall tally
  int now = 0;
  int m_ts = 0;
  int m_n = 0;
  bit m_valid = 1'b0;
  logic [31:0] m_cnt = 32'd0;

  typedef struct {
    logic [4:0] rs, rt, we, wm;
    logic [1:0] tu_rs, tu_rt, ne, nm;
    bit exp;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, now, act, exp);
    end
  endtask

  function automatic bit hz(input logic [4:0] r, input logic [1:0] tu, input logic [4:0] we,
                            input logic [1:0] ne, input logic [4:0] wm, input logic [1:0] nm);
    if (r == 5'd0 || tu == 2'd3) return 1'b0;
    return (r == we && int'(tu) < int'(ne)) || (r == wm && int'(tu) < int'(nm));
  endfunction

  task automatic clr();
    rs_D = 0; rt_D = 0; wreg_E = 0; wreg_M = 0;
    tuse_rs_D = 3; tuse_rt_D = 3; tnew_E = 0; tnew_M = 0;
    md_start_E = 0; md_is_div_E = 0; md_use_D = 0; RESET = 0;
  endtask

  // called at a negedge with inputs already applied; checks, advances model, returns at next negedge
  task automatic cyc();
    bit eb, ed, es;
    #2;
    eb = m_valid && now > m_ts && now <= m_ts + m_n;
    ed = m_valid && now == m_ts + m_n + 1;
    es = !RESET && (hz(rs_D, tuse_rs_D, wreg_E, tnew_E, wreg_M, tnew_M) ||
                    hz(rt_D, tuse_rt_D, wreg_E, tnew_E, wreg_M, tnew_M) ||
                    (md_use_D && (eb || md_start_E)));
    chk("md_busy", md_busy, eb);
    chk("md_done", md_done, ed);
    chk("stall_PC", stall_PC, es);
    chk("stall_FtoD", stall_FtoD, es);
    chk("flush_DtoE", flush_DtoE, es);
`ifdef STALL_PERF_CNT_EN
    chk("stall_cnt", stall_cnt, m_cnt);
`endif
    if (RESET) begin
      m_valid = 1'b0;
      m_cnt = 32'd0;
    end else begin
      if (md_start_E) begin
        m_valid = 1'b1;
        m_ts = now;
        m_n = md_is_div_E ? 10 : 5;
      end
      if (es) m_cnt = m_cnt + 32'd1;
    end
    now++;
    @(negedge CLK);
  endtask

  initial begin
    vecs[0] = '{rs:8, rt:0, we:8, wm:0, tu_rs:1, tu_rt:3, ne:2, nm:0, exp:1};
    vecs[1] = '{rs:8, rt:0, we:0, wm:8, tu_rs:1, tu_rt:3, ne:0, nm:1, exp:0};
    vecs[2] = '{rs:0, rt:0, we:0, wm:0, tu_rs:0, tu_rt:3, ne:2, nm:0, exp:0};
    vecs[3] = '{rs:0, rt:9, we:9, wm:0, tu_rs:3, tu_rt:1, ne:1, nm:0, exp:0};
    vecs[4] = '{rs:0, rt:9, we:9, wm:0, tu_rs:3, tu_rt:3, ne:2, nm:0, exp:0};
    vecs[5] = '{rs:0, rt:9, we:0, wm:9, tu_rs:3, tu_rt:0, ne:0, nm:1, exp:1};
    vecs[6] = '{rs:5, rt:0, we:5, wm:0, tu_rs:0, tu_rt:3, ne:1, nm:0, exp:1};
    vecs[7] = '{rs:5, rt:0, we:5, wm:0, tu_rs:2, tu_rt:3, ne:2, nm:0, exp:0};
    vecs[8] = '{rs:7, rt:7, we:7, wm:0, tu_rs:3, tu_rt:1, ne:2, nm:0, exp:1};
    vecs[9] = '{rs:3, rt:0, we:0, wm:4, tu_rs:0, tu_rt:3, ne:0, nm:1, exp:0};
    clr();
    RESET = 1;
    repeat (2) @(negedge CLK);
    RESET = 0;
    cyc();
    foreach (vecs[i]) begin
      rs_D = vecs[i].rs; rt_D = vecs[i].rt; wreg_E = vecs[i].we; wreg_M = vecs[i].wm;
      tuse_rs_D = vecs[i].tu_rs; tuse_rt_D = vecs[i].tu_rt; tnew_E = vecs[i].ne; tnew_M = vecs[i].nm;
      #2 chk($sformatf("vec%0d", i), stall_PC, vecs[i].exp);
      cyc();
    end
    clr();
    for (int c = 0; c < 8; c++) begin
      md_start_E = (c == 0); md_is_div_E = 0; md_use_D = (c <= 6);
      #2;
      chk("mult_busy", md_busy, c >= 1 && c <= 5);
      chk("mult_done", md_done, c == 6);
      chk("mult_stall", stall_PC, c <= 5);
      cyc();
    end
    clr();
    for (int c = 0; c < 11; c++) begin
      md_start_E = (c == 0 || c == 3); md_is_div_E = (c == 0);
      #2;
      chk("restart_busy", md_busy, c >= 1 && c <= 8);
      chk("restart_done", md_done, c == 9);
      cyc();
    end
    clr();
    for (int c = 0; c < 14; c++) begin
      md_start_E = (c == 0); md_is_div_E = 1; RESET = (c == 4);
      md_use_D = (c == 4); rs_D = (c == 4) ? 5'd8 : 5'd0; wreg_E = rs_D; tnew_E = 2; tuse_rs_D = 1;
      #2;
      chk("rst_busy", md_busy, c >= 1 && c <= 4);
      chk("rst_done", md_done, 0);
      if (c == 4) chk("rst_stall_forced", stall_PC, 0);
      cyc();
    end
`ifdef STALL_PERF_CNT_EN
    clr();
    RESET = 1;
    cyc();
    RESET = 0;
    chk("perf_reset", stall_cnt, 0);
    for (int c = 0; c < 3; c++) begin
      rs_D = 8; tuse_rs_D = 1; wreg_E = 8; tnew_E = 2;
      cyc();
    end
    clr();
    for (int c = 0; c < 8; c++) begin
      md_start_E = (c == 0); md_use_D = (c <= 4);
      cyc();
    end
    clr();
    chk("perf_count", stall_cnt, 8);
    RESET = 1;
    cyc();
    RESET = 0;
    chk("perf_clear", stall_cnt, 0);
`endif
    for (int k = 0; k < 500; k++) begin
      RESET = ($urandom_range(0, 59) == 0);
      rs_D = 5'($urandom_range(0, 3)); rt_D = 5'($urandom_range(0, 3));
      wreg_E = 5'($urandom_range(0, 3)); wreg_M = 5'($urandom_range(0, 3));
      tuse_rs_D = 2'($urandom_range(0, 3)); tuse_rt_D = 2'($urandom_range(0, 3));
      tnew_E = 2'($urandom_range(0, 2)); tnew_M = 2'($urandom_range(0, 1));
      md_start_E = ($urandom_range(0, 7) == 0); md_is_div_E = 1'($urandom_range(0, 1));
      md_use_D = 1'($urandom_range(0, 1));
      cyc();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
